// File: rtl/pipeline_stall_ctrl_pkg.sv
// rtl/pipeline_stall_ctrl_pkg.sv - shared state encoding and defaults for the stall controller
package pipeline_stall_ctrl_pkg;

  localparam int DEFAULT_CNT_WIDTH = 32;

  // Encoding 2 is reserved; the FSM recovers from it to ST_RUN.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_RSVD     = 2'd2,
    ST_ERROR    = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// rtl/pipeline_stall_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count enabled cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && !(&count)) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline freeze/flush/bubble controller with memory-wait timeout
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hazard_detected,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 freeze_pc,
  output logic                 freeze_if_id,
  output logic                 flush_if_id,
  output logic                 bubble_id_ex,
  output logic                 freeze_back,
  output logic [1:0]           ctrl_state,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic                 mem_timeout_err
);

  // Wide enough to hold MEM_TIMEOUT itself so the increment never wraps.
  localparam int TW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  ctrl_state_e          state;
  ctrl_state_e          state_nxt;
  logic [TW-1:0]        wait_tmr;
  logic [TW-1:0]        wait_tmr_nxt;

  logic                 f_pc;
  logic                 f_if_id;
  logic                 f_flush;
  logic                 f_bubble;
  logic                 f_back;
  logic                 f_err;

  logic [CNT_WIDTH-1:0] stall_q;
  logic [CNT_WIDTH-1:0] flush_q;

  // State and wait-timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_tmr <= '0;
    end else begin
      state    <= state_nxt;
      wait_tmr <= wait_tmr_nxt;
    end
  end

  // Next-state and raw control outputs; memory stall beats branch beats hazard.
  always_comb begin
    state_nxt    = state;
    wait_tmr_nxt = wait_tmr;
    f_pc         = 1'b0;
    f_if_id      = 1'b0;
    f_flush      = 1'b0;
    f_bubble     = 1'b0;
    f_back       = 1'b0;
    f_err        = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          f_pc         = 1'b1;
          f_if_id      = 1'b1;
          f_back       = 1'b1;
          state_nxt    = ST_MEM_WAIT;
          wait_tmr_nxt = '0;
        end else if (branch_taken) begin
          f_flush  = 1'b1;
          f_bubble = 1'b1;
        end else if (hazard_detected) begin
          f_pc     = 1'b1;
          f_if_id  = 1'b1;
          f_bubble = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = ST_RUN;
        end else begin
          f_pc         = 1'b1;
          f_if_id      = 1'b1;
          f_back       = 1'b1;
          wait_tmr_nxt = wait_tmr + TW'(1);
          if (wait_tmr == TMO_LAST) begin
            state_nxt = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        f_pc    = 1'b1;
        f_if_id = 1'b1;
        f_back  = 1'b1;
        f_err   = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Reset masks every output in the cycle it is asserted.
  assign freeze_pc       = !rst && f_pc;
  assign freeze_if_id    = !rst && f_if_id;
  assign flush_if_id     = !rst && f_flush;
  assign bubble_id_ex    = !rst && f_bubble;
  assign freeze_back     = !rst && f_back;
  assign mem_timeout_err = !rst && f_err;
  assign ctrl_state      = rst ? 2'b00 : state;
  assign stall_cnt       = rst ? '0 : stall_q;
  assign flush_cnt       = rst ? '0 : flush_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (freeze_pc),
    .count (stall_q)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (flush_if_id),
    .count (flush_q)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard_detected = 1'b0;
  logic branch_taken = 1'b0;
  logic mem_req = 1'b0;
  logic mem_ready = 1'b0;

  logic        a_fpc, a_fif, a_flush, a_bub, a_fback, a_err;
  logic [1:0]  a_state;
  logic [31:0] a_stall, a_flcnt;
  logic        b_fpc, b_fif, b_flush, b_bub, b_fback, b_err;
  logic [1:0]  b_state;
  logic [3:0]  b_stall, b_flcnt;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_WIDTH(32), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .freeze_pc(a_fpc), .freeze_if_id(a_fif),
    .flush_if_id(a_flush), .bubble_id_ex(a_bub), .freeze_back(a_fback), .ctrl_state(a_state),
    .stall_cnt(a_stall), .flush_cnt(a_flcnt), .mem_timeout_err(a_err)
  );

  pipeline_stall_ctrl #(.CNT_WIDTH(4), .MEM_TIMEOUT(TMO)) dut4 (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .freeze_pc(b_fpc), .freeze_if_id(b_fif),
    .flush_if_id(b_flush), .bubble_id_ex(b_bub), .freeze_back(b_fback), .ctrl_state(b_state),
    .stall_cnt(b_stall), .flush_cnt(b_flcnt), .mem_timeout_err(b_err)
  );

  int vecs = 0;
  int miscompares = 0;
  bit done = 1'b0;

  // Model: mode 0 = running, 1 = waiting on memory, 3 = locked in timeout error.
  int     m_mode = 0;
  int     m_waited = 0;
  longint m_stall = 0;
  longint m_flush = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint top;
    top = (longint'(1) << w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic model_step();
    bit fpc, fif, fl, bub, fb, er;
    int st, nmode, nwaited;
    longint es, ef;
    fpc = 0; fif = 0; fl = 0; bub = 0; fb = 0; er = 0;
    st = m_mode; nmode = m_mode; nwaited = m_waited;
    es = m_stall; ef = m_flush;
    if (rst) begin
      st = 0; es = 0; ef = 0;
      nmode = 0; nwaited = 0;
    end else if (m_mode == 3) begin
      fpc = 1; fif = 1; fb = 1; er = 1;
    end else if (m_mode == 1) begin
      if (!mem_ready) begin
        fpc = 1; fif = 1; fb = 1;
        nwaited = m_waited + 1;
        if (nwaited == TMO) nmode = 3;
      end else begin
        nmode = 0;
      end
    end else begin
      if (mem_req && !mem_ready) begin
        fpc = 1; fif = 1; fb = 1;
        nmode = 1; nwaited = 0;
      end else if (branch_taken) begin
        fl = 1; bub = 1;
      end else if (hazard_detected) begin
        fpc = 1; fif = 1; bub = 1;
      end
    end
    chk("freeze_pc", a_fpc, fpc);       chk("freeze_pc_w4", b_fpc, fpc);
    chk("freeze_if_id", a_fif, fif);    chk("freeze_if_id_w4", b_fif, fif);
    chk("flush_if_id", a_flush, fl);    chk("flush_if_id_w4", b_flush, fl);
    chk("bubble_id_ex", a_bub, bub);    chk("bubble_id_ex_w4", b_bub, bub);
    chk("freeze_back", a_fback, fb);    chk("freeze_back_w4", b_fback, fb);
    chk("timeout_err", a_err, er);      chk("timeout_err_w4", b_err, er);
    chk("ctrl_state", a_state, st);     chk("ctrl_state_w4", b_state, st);
    chk("stall_cnt", a_stall, sat(es, 32)); chk("stall_cnt_w4", b_stall, sat(es, 4));
    chk("flush_cnt", a_flcnt, sat(ef, 32)); chk("flush_cnt_w4", b_flcnt, sat(ef, 4));
    if (rst) begin
      m_stall = 0; m_flush = 0;
    end else begin
      m_stall = m_stall + longint'(fpc);
      m_flush = m_flush + longint'(fl);
    end
    m_mode = nmode;
    m_waited = nwaited;
  endtask

  // Inputs change just after the rising edge, so the falling edge sees settled outputs.
  always @(negedge clk) begin
    if (!done) model_step();
  end

  task automatic cyc(input bit r, input bit h, input bit b, input bit q, input bit y);
    @(posedge clk);
    #1;
    rst = r; hazard_detected = h; branch_taken = b; mem_req = q; mem_ready = y;
    @(negedge clk);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("lit_rst_state", a_state, 0);
    chk("lit_rst_stall", a_stall, 0);
    chk("lit_rst_fpc", a_fpc, 0);

    // Two hazard cycles.
    cyc(0, 1, 0, 0, 0);
    chk("lit_haz1_fpc", a_fpc, 1); chk("lit_haz1_fif", a_fif, 1); chk("lit_haz1_bub", a_bub, 1);
    cyc(0, 1, 0, 0, 0);
    chk("lit_haz2_fpc", a_fpc, 1); chk("lit_haz2_fif", a_fif, 1); chk("lit_haz2_bub", a_bub, 1);
    cyc(0, 0, 0, 0, 0);
    chk("lit_haz_stall", a_stall, 2);

    // Branch overrides hazard.
    cyc(0, 1, 1, 0, 0);
    chk("lit_br_flush", a_flush, 1); chk("lit_br_bub", a_bub, 1); chk("lit_br_fpc", a_fpc, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit_br_flcnt", a_flcnt, 1);

    // Single-cycle memory access lets the branch through.
    cyc(0, 0, 1, 1, 1);
    chk("lit_mem1_flush", a_flush, 1); chk("lit_mem1_fback", a_fback, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit_mem1_flcnt", a_flcnt, 2);

    // Three-cycle memory stall.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("lit_mw_fb1", a_fback, 1);
    cyc(0, 1, 1, 1, 0);
    chk("lit_mw_fb2", a_fback, 1); chk("lit_mw_state", a_state, 1); chk("lit_mw_noflush", a_flush, 0);
    cyc(0, 0, 0, 1, 0);
    chk("lit_mw_fb3", a_fback, 1);
    cyc(0, 0, 0, 1, 1);
    chk("lit_mw_rdy_fb", a_fback, 0); chk("lit_mw_rdy_fpc", a_fpc, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit_mw_back_run", a_state, 0); chk("lit_mw_stall", a_stall, 3);

    // Ready arrives on the would-be timeout cycle.
    cyc(0, 0, 0, 1, 0);
    repeat (TMO - 1) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    chk("lit_edge_state", a_state, 1); chk("lit_edge_fb", a_fback, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit_edge_run", a_state, 0); chk("lit_edge_err", a_err, 0);

    // Full timeout into ERROR.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (TMO) cyc(0, 0, 0, 1, 0);
    chk("lit_tmo_last_wait", a_state, 1);
    cyc(0, 0, 0, 1, 1);
    chk("lit_tmo_state", a_state, 3); chk("lit_tmo_err", a_err, 1); chk("lit_tmo_fb", a_fback, 1);
    cyc(0, 1, 1, 0, 0);
    chk("lit_tmo_stays", a_state, 3); chk("lit_tmo_noflush", a_flush, 0);
    chk("lit_tmo_stall", a_stall, 18);

    // Reset out of ERROR.
    cyc(1, 0, 0, 0, 0);
    chk("lit_rsterr_fpc", a_fpc, 0); chk("lit_rsterr_err", a_err, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit_post_state", a_state, 0); chk("lit_post_stall", a_stall, 0);
    chk("lit_post_flcnt", a_flcnt, 0); chk("lit_post_fb", a_fback, 0); chk("lit_post_fpc", a_fpc, 0);

    // Saturation of the 4-bit counter.
    repeat (20) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit_sat_w4", b_stall, 15);
    chk("lit_sat_w32", a_stall, 20);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
